mult_acc_win: RTL and testbench
===============================

# mult_acc_win

Windowed accumulator directly downstream of the pipelined shift-add multiplier `mult_man`. It consumes the multiplier's `result`/`result_ready` stream and sums a fixed window of L products. It emits each completed sum with a one-cycle valid pulse. Flush and clear controls close or discard a partial window, so the pair forms a small MAC datapath.

## Interface
- `N`, default 8: multiplicand width; must match the upstream multiplier.
- `M`, default 4: multiplier width; must match the upstream multiplier.
- `L`, default 8: products per window; power of two, ≥2.
- `LW`, default clog2(L): derived, not overridden.
- `ACC_W`, default N+M+LW: derived accumulator/sum width; cannot overflow.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `result_ready`, input, 1: product valid, from the multiplier.
- `result`, input, N+M: unsigned product, from the multiplier.
- `flush`, input, 1: close the current partial window and emit it.
- `acc_clr`, input, 1: discard the current partial window, with no output.
- `sum_valid`, output, 1: one-cycle pulse; `sum` and `sum_cnt` are new.
- `sum`, output, ACC_W: accumulated window sum; held between pulses.
- `sum_cnt`, output, LW+1: number of products included in `sum` (1..L).
- `busy`, output, 1: high while the window holds ≥1 product (state ACC).

## Operation
- A product is accepted at a rising edge where `result_ready`=1. `result` is zero-extended to ACC_W.
- Internal registers: `acc` (ACC_W bits), `cnt` (LW+1 bits), and a 2-state FSM.
- **IDLE** (`cnt`=0, `acc`=0, `busy`=0):
  - Accept → `acc`=result, `cnt`=1, go to ACC.
  - Exception: when L... (L≥2, so no immediate completion).
- **ACC** (`busy`=1): on accept, `acc`+=result and `cnt`+=1.
- Window complete: the accepted product is the L-th of the window.
  - `sum`←acc+result, `sum_cnt`←L, `sum_valid`←1.
  - `acc`←0, `cnt`←0, go to IDLE.
  - The next product is accepted on the very next edge with no bubble.
- `flush`=1 in ACC:
  - Emit `acc` (+result if accepted the same edge) with the matching `sum_cnt`.
  - Clear the window and go to IDLE.
- `flush`=1 in IDLE with `result_ready`=1:
  - Emit that single product, `sum_cnt`=1.
- `flush`=1 in IDLE with `result_ready`=0: no-op, no pulse.
- Window completion and `flush` on the same edge: a single emission (the L-product sum). No extra pulse.
- `acc_clr`=1 has highest priority:
  - `acc`←0, `cnt`←0, go to IDLE, no pulse.
  - A product presented on that edge is dropped.
  - `flush` on that edge is ignored.
- `sum`/`sum_cnt` are updated only on emission. `acc_clr` does not alter them.
- Arithmetic is unsigned. Worst case L·(2^N−1)(2^M−1) fits ACC_W, so no saturation logic is required.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` release):
  - `sum_valid`=0, `sum`=0, `sum_cnt`=0, `busy`=0.
  - `acc`=0, `cnt`=0, state IDLE.
- Reset mid-window discards the partial sum; no emission.
- Latency: `sum_valid` rises in the cycle following the edge that accepts the L-th product or samples `flush`. Width is exactly 1 cycle unless the next window also completes.
- Back-to-back windows under continuous `result_ready`: `sum_valid` pulses every L cycles.
- No backpressure: this block always accepts. Upstream `result_ready` is never stalled.
- `busy` reflects the registered state; it updates on the same edge as `cnt`.

## Test plan
- **Reset:** hold `rst_n`=0 with `result_ready`=1.
  - All outputs stay 0.
  - After release, the first accepted product starts a window at `cnt`=1.
- **Single window:** 8 consecutive products of 125 (25×5).
  - One `sum_valid` pulse, the cycle after the 8th product.
  - `sum`=1000, `sum_cnt`=8, `busy` then 0.
- **Back-to-back, max values:** 16 consecutive products of 3825 (255×15).
  - Two pulses exactly 8 cycles apart, each with `sum`=30600 and `sum_cnt`=8.
  - No dropped product at the boundary.
- **Gapped input:** products 10, 20, 30, 40, 50, 60, 70, 80 with `result_ready` low every other cycle.
  - `sum`=360, `sum_cnt`=8.
  - Pulse the cycle after the 80 is accepted.
- **Flush:**
  - Case 1: three products of 100, then `flush` alone → `sum`=300, `sum_cnt`=3.
  - Case 2: two products of 100, then `flush` with product 50 on the same edge → `sum`=250, `sum_cnt`=3.
  - Case 3: `flush` while IDLE with no product → no pulse.
  - Case 4: 8th product coincident with `flush` → exactly one pulse, `sum_cnt`=8.
- **Clear/reset mid-window:**
  - Case 1: five products of 7, then `acc_clr` with a product 9 on the same edge.
    - No pulse; `sum` keeps its previous value.
    - The next 8 products of 1 give `sum`=8.
  - Case 2: assert `rst_n`=0 mid-window → outputs zero immediately (asynchronously).

Source files
------------

// File: rtl/mult_acc_win_if.sv
// Product stream in, windowed sum out, between the multiplier-side driver and
// the windowed accumulator.
interface mult_acc_win_if #(
   parameter int unsigned N = 8,
   parameter int unsigned M = 4,
   parameter int unsigned L = 8
);
   localparam int unsigned LW    = $clog2(L);
   localparam int unsigned ACC_W = N + M + LW;

   logic             result_ready;
   logic [N+M-1:0]   result;
   logic             flush;
   logic             acc_clr;
   logic             sum_valid;
   logic [ACC_W-1:0] sum;
   logic [LW:0]      sum_cnt;
   logic             busy;

   modport master (
      output result_ready, result, flush, acc_clr,
      input  sum_valid, sum, sum_cnt, busy
   );

   modport slave (
      input  result_ready, result, flush, acc_clr,
      output sum_valid, sum, sum_cnt, busy
   );
endinterface

// File: rtl/mult_acc_win.sv
// Windowed accumulator: sums L consecutive products from the multiplier and
// emits each completed (or flushed) window sum with a one-cycle valid pulse.
module mult_acc_win #(
   parameter int unsigned N = 8,
   parameter int unsigned M = 4,
   parameter int unsigned L = 8
) (
   input logic           clk,
   input logic           rst_n,
   mult_acc_win_if.slave bus
);
   localparam int unsigned LW    = $clog2(L);
   localparam int unsigned ACC_W = N + M + LW;
   localparam int unsigned CNT_W = LW + 1;

   typedef enum logic {StIdle, StAcc} state_e;

   state_e           state_q;
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sum_valid_q;
   logic [ACC_W-1:0] sum_q;
   logic [CNT_W-1:0] sum_cnt_q;

   logic [ACC_W-1:0] add_val;
   logic [ACC_W-1:0] acc_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             win_done;
   logic             emit;

   // Window contents after this edge's accept; IDLE already holds acc=0/cnt=0,
   // so the same arithmetic covers starting a fresh window.
   always_comb begin
      add_val  = bus.result_ready ? {{LW{1'b0}}, bus.result} : '0;
      acc_nxt  = acc_q + add_val;
      cnt_nxt  = cnt_q + CNT_W'(bus.result_ready);
      win_done = bus.result_ready && (cnt_nxt == CNT_W'(L));
      // A full window and a flush on the same edge collapse into one emission.
      emit     = win_done || (bus.flush && (cnt_nxt != '0));
   end

   // FSM, window registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         cnt_q       <= '0;
         sum_valid_q <= 1'b0;
         sum_q       <= '0;
         sum_cnt_q   <= '0;
      end else if (bus.acc_clr) begin
         // Clear wins over everything: drop the product, ignore flush, keep sum.
         state_q     <= StIdle;
         acc_q       <= '0;
         cnt_q       <= '0;
         sum_valid_q <= 1'b0;
      end else if (emit) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         cnt_q       <= '0;
         sum_valid_q <= 1'b1;
         sum_q       <= acc_nxt;
         sum_cnt_q   <= cnt_nxt;
      end else begin
         state_q     <= (cnt_nxt != '0) ? StAcc : StIdle;
         acc_q       <= acc_nxt;
         cnt_q       <= cnt_nxt;
         sum_valid_q <= 1'b0;
      end
   end

   assign bus.sum_valid = sum_valid_q;
   assign bus.sum       = sum_q;
   assign bus.sum_cnt   = sum_cnt_q;
   assign bus.busy      = (state_q == StAcc);
endmodule

// File: tb/tb_mult_acc_win.sv
// Bench for mult_acc_win: directed table, hand-written corner sequences and
// random traffic checked against a queue-based window model.
module tb_mult_acc_win;
   localparam int unsigned N     = 8;
   localparam int unsigned M     = 4;
   localparam int unsigned L     = 8;
   localparam int unsigned LW    = $clog2(L);
   localparam int unsigned ACC_W = N + M + LW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mult_acc_win_if #(.N(N), .M(M), .L(L)) bus ();
   mult_acc_win #(.N(N), .M(M), .L(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: the open window is just a list of accepted products.
   int unsigned win[$];
   int unsigned m_sum   = 0;
   int unsigned m_cnt   = 0;
   bit          m_valid = 1'b0;

   typedef struct {
      bit          rr;
      int unsigned res;
      bit          fl;
      bit          clr;
      bit          ev;
      int unsigned es;
      int unsigned ec;
      bit          eb;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model(input bit rr, input int unsigned res, input bit fl,
                                 input bit clr);
      int unsigned s;
      m_valid = 1'b0;
      if (clr) begin
         win.delete();
      end else begin
         if (rr) win.push_back(res);
         if (win.size() == L || (fl && win.size() > 0)) begin
            s = 0;
            foreach (win[i]) s += win[i];
            m_sum   = s;
            m_cnt   = win.size();
            m_valid = 1'b1;
            win.delete();
         end
      end
   endfunction

   task automatic model_reset();
      win.delete();
      m_sum   = 0;
      m_cnt   = 0;
      m_valid = 1'b0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, 32'(bus.sum_valid), 32'(m_valid));
      chk({tag, ".sum"}, 32'(bus.sum), m_sum);
      chk({tag, ".cnt"}, 32'(bus.sum_cnt), m_cnt);
      chk({tag, ".busy"}, 32'(bus.busy), 32'(win.size() > 0));
   endtask

   task automatic drive(input bit rr, input int unsigned res, input bit fl, input bit clr);
      bus.result_ready = rr;
      bus.result       = (N+M)'(res);
      bus.flush        = fl;
      bus.acc_clr      = clr;
      @(posedge clk);
      cyc++;
      model(rr, res, fl, clr);
      #1;
   endtask

   task automatic step(input string tag, input bit rr, input int unsigned res, input bit fl,
                       input bit clr);
      drive(rr, res, fl, clr);
      check_model(tag);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".valid"}, 32'(bus.sum_valid), 0);
      chk({tag, ".sum"}, 32'(bus.sum), 0);
      chk({tag, ".cnt"}, 32'(bus.sum_cnt), 0);
      chk({tag, ".busy"}, 32'(bus.busy), 0);
   endtask

   initial begin
      int pulses[$];
      int unsigned held;

      // Reset held with a product presented: nothing may move.
      bus.result_ready = 1'b1;
      bus.result       = (N+M)'(5);
      bus.flush        = 1'b0;
      bus.acc_clr      = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_zero("reset_hold");
      end
      rst_n = 1'b1;
      model_reset();

      // Directed table from a fresh post-reset state.
      tbl.push_back('{1'b1, 100, 1'b0, 1'b0, 1'b0,   0, 0, 1'b1});
      tbl.push_back('{1'b1, 100, 1'b0, 1'b0, 1'b0,   0, 0, 1'b1});
      tbl.push_back('{1'b1,  50, 1'b1, 1'b0, 1'b1, 250, 3, 1'b0});
      tbl.push_back('{1'b0,   0, 1'b1, 1'b0, 1'b0, 250, 3, 1'b0});
      tbl.push_back('{1'b1, 100, 1'b0, 1'b0, 1'b0, 250, 3, 1'b1});
      tbl.push_back('{1'b1, 100, 1'b0, 1'b0, 1'b0, 250, 3, 1'b1});
      tbl.push_back('{1'b1, 100, 1'b0, 1'b0, 1'b0, 250, 3, 1'b1});
      tbl.push_back('{1'b0,   0, 1'b1, 1'b0, 1'b1, 300, 3, 1'b0});
      tbl.push_back('{1'b0,   0, 1'b0, 1'b0, 1'b0, 300, 3, 1'b0});
      tbl.push_back('{1'b1,   7, 1'b0, 1'b0, 1'b0, 300, 3, 1'b1});
      tbl.push_back('{1'b1,   9, 1'b1, 1'b1, 1'b0, 300, 3, 1'b0});
      tbl.push_back('{1'b0,   0, 1'b0, 1'b0, 1'b0, 300, 3, 1'b0});
      foreach (tbl[i]) begin
         drive(tbl[i].rr, tbl[i].res, tbl[i].fl, tbl[i].clr);
         chk("tbl.valid", 32'(bus.sum_valid), 32'(tbl[i].ev));
         chk("tbl.sum", 32'(bus.sum), tbl[i].es);
         chk("tbl.cnt", 32'(bus.sum_cnt), tbl[i].ec);
         chk("tbl.busy", 32'(bus.busy), 32'(tbl[i].eb));
      end

      // Single window of 125s.
      for (int i = 0; i < 8; i++) step("single", 1'b1, 125, 1'b0, 1'b0);
      chk("single.sum_const", 32'(bus.sum), 1000);
      chk("single.cnt_const", 32'(bus.sum_cnt), 8);
      step("single_after", 1'b0, 0, 1'b0, 1'b0);

      // Back-to-back full-scale windows: pulses every L cycles.
      for (int i = 0; i < 16; i++) begin
         step("b2b", 1'b1, 3825, 1'b0, 1'b0);
         if (bus.sum_valid) begin
            pulses.push_back(cyc);
            chk("b2b.sum_const", 32'(bus.sum), 30600);
         end
      end
      chk("b2b.pulses", pulses.size(), 2);
      if (pulses.size() == 2) chk("b2b.spacing", 32'(pulses[1] - pulses[0]), 8);
      step("b2b_after", 1'b0, 0, 1'b0, 1'b0);

      // Gapped input.
      for (int i = 1; i <= 8; i++) begin
         step("gap", 1'b1, 10 * i, 1'b0, 1'b0);
         if (i < 8) step("gap_idle", 1'b0, 0, 1'b0, 1'b0);
      end
      chk("gap.valid_const", 32'(bus.sum_valid), 1);
      chk("gap.sum_const", 32'(bus.sum), 360);

      // Full window coinciding with flush: one emission only.
      for (int i = 0; i < 7; i++) step("fl4", 1'b1, 2, 1'b0, 1'b0);
      step("fl4_last", 1'b1, 2, 1'b1, 1'b0);
      chk("fl4.sum_const", 32'(bus.sum), 16);
      chk("fl4.cnt_const", 32'(bus.sum_cnt), 8);
      step("fl4_after", 1'b0, 0, 1'b0, 1'b0);

      // Clear mid-window drops the partial sum and the coincident product.
      held = bus.sum;
      for (int i = 0; i < 5; i++) step("clr", 1'b1, 7, 1'b0, 1'b0);
      step("clr_edge", 1'b1, 9, 1'b0, 1'b1);
      chk("clr.held_sum", 32'(bus.sum), held);
      for (int i = 0; i < 8; i++) step("clr_ones", 1'b1, 1, 1'b0, 1'b0);
      chk("clr.ones_sum", 32'(bus.sum), 8);

      // Asynchronous reset mid-window.
      for (int i = 0; i < 3; i++) step("arst", 1'b1, 40, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_zero("arst_now");
      bus.result_ready = 1'b0;
      @(posedge clk);
      #1;
      check_zero("arst_hold");
      rst_n = 1'b1;
      step("arst_first", 1'b1, 5, 1'b1, 1'b0);
      chk("arst_first.cnt_const", 32'(bus.sum_cnt), 1);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 255) * $urandom_range(0, 15),
              $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
